// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into an instruction template and queues
// {inst, addr} in a 2-entry FIFO. Optional range checking: define IMM_ENC_RANGE_CHECK_EN.
module imm_encoder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b101;
  localparam logic [2:0] FMT_U = 3'b010;
  localparam logic [2:0] FMT_J = 3'b110;

  function automatic logic fmt_legal(input logic [2:0] src);
    logic ok;
    case (src)
      FMT_I, FMT_S, FMT_B, FMT_U, FMT_J: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Overwriting every immediate-field bit is equivalent to masking then filling.
  function automatic logic [31:0] encode(input logic [31:0] v, input logic [2:0] src,
                                         input logic [31:0] tmpl);
    logic [31:0] w;
    w = tmpl;
    case (src)
      FMT_I: w[31:20] = v[11:0];
      FMT_S: begin
        w[31:25] = v[11:5];
        w[11:7]  = v[4:0];
      end
      FMT_B: begin
        w[31]    = v[12];
        w[30:25] = v[10:5];
        w[11:8]  = v[4:1];
        w[7]     = v[11];
      end
      FMT_U: w[31:12] = v[31:12];
      FMT_J: begin
        w[31]    = v[20];
        w[30:21] = v[10:1];
        w[20]    = v[11];
        w[19:12] = v[19:12];
      end
      default: w = tmpl;
    endcase
    return w;
  endfunction

`ifdef IMM_ENC_RANGE_CHECK_EN
  function automatic logic range_ok(input logic [31:0] v, input logic [2:0] src);
    logic ok;
    case (src)
      FMT_I, FMT_S: ok = (&v[31:11]) | ~(|v[31:11]);
      FMT_B:        ok = ((&v[31:12]) | ~(|v[31:12])) & ~v[0];
      FMT_J:        ok = ((&v[31:20]) | ~(|v[31:20])) & ~v[0];
      FMT_U:        ok = ~(|v[11:0]);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  logic [1:0]  count_r;
  logic [31:0] head_inst_r, head_addr_r;
  logic [31:0] tail_inst_r, tail_addr_r;
  logic [31:0] addr_r;
  logic        err_r;
  logic [7:0]  err_count_r;

  logic        accept_s, pop_s, word_ok_s, push_s, reject_s;
  logic [31:0] enc_inst_s;

  assign in_ready   = (count_r != 2'd2);
  assign out_valid  = (count_r != 2'd0);
  assign out_inst   = head_inst_r;
  assign out_addr   = head_addr_r;
  assign err        = err_r;
  assign err_count  = err_count_r;

  assign enc_inst_s = encode(imm, imm_src, base);
`ifdef IMM_ENC_RANGE_CHECK_EN
  assign word_ok_s  = fmt_legal(imm_src) & range_ok(imm, imm_src);
`else
  assign word_ok_s  = fmt_legal(imm_src);
`endif
  assign accept_s   = in_valid & in_ready;
  assign pop_s      = out_valid & out_ready;
  assign push_s     = accept_s & word_ok_s;
  assign reject_s   = accept_s & ~word_ok_s;

  // Address counter and sticky error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= ADDR_BASE;
      err_r       <= 1'b0;
      err_count_r <= 8'h00;
    end else if (clr) begin
      addr_r      <= ADDR_BASE;
      err_r       <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      if (push_s) begin
        addr_r <= addr_r + 32'd4;
      end
      if (reject_s) begin
        err_r <= 1'b1;
        if (err_count_r != 8'hFF) begin
          err_count_r <= err_count_r + 8'd1;
        end
      end
    end
  end

  // Two-slot FIFO; the head slot doubles as the registered output and holds when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= 2'd0;
      head_inst_r <= 32'h0000_0000;
      head_addr_r <= ADDR_BASE;
      tail_inst_r <= 32'h0000_0000;
      tail_addr_r <= 32'h0000_0000;
    end else if (clr) begin
      count_r <= 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_inst_r <= enc_inst_s;
            head_addr_r <= addr_r;
            count_r     <= 2'd1;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_inst_r <= enc_inst_s;
            head_addr_r <= addr_r;
          end else if (push_s) begin
            tail_inst_r <= enc_inst_s;
            tail_addr_r <= addr_r;
            count_r     <= 2'd2;
          end else if (pop_s) begin
            count_r <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_inst_r <= tail_inst_r;
            head_addr_r <= tail_addr_r;
            count_r     <= 2'd1;
          end
        end
        default: count_r <= 2'd0;
      endcase
    end
  end

endmodule
